// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin share of the register-file write port between A and B.
// Optional post-reset zeroing sweep of x1..x31 is compiled in with `RF_CLEAR_EN.
//
// state   | meaning
// CLEAR   | zeroing sweep, one register per cycle, requesters stalled
// RUN     | normal arbitration of A/B onto the write port
module rf_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        rf_we,
    output logic        busy
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state, state_nxt;
    logic        rr, rr_nxt;           // 0: A wins the next contest, 1: B
    logic        we_nxt;
    logic [4:0]  wa_nxt;
    logic [31:0] wd_nxt;
    logic        a_acc, b_acc;

`ifdef RF_CLEAR_EN
    logic [4:0]  idx, idx_nxt;
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_RUN;
`endif

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        a_acc     = 1'b0;
        b_acc     = 1'b0;
        we_nxt    = 1'b0;
        wa_nxt    = rf_wa;
        wd_nxt    = rf_wd;
        busy      = 1'b0;
`ifdef RF_CLEAR_EN
        idx_nxt   = idx;
`endif
        case (state)
`ifdef RF_CLEAR_EN
            S_CLEAR: begin
                busy = 1'b1;
                // idx wraps to 0 after the write to x31
                if (idx == 5'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    we_nxt  = 1'b1;
                    wa_nxt  = idx;
                    wd_nxt  = 32'd0;
                    idx_nxt = idx + 5'd1;
                end
            end
`endif
            S_RUN: begin
                // readies are forced low while rst is asserted
                a_ready = rst & (!b_valid | !rr);
                b_ready = rst & (!a_valid | rr);
                a_acc   = a_valid & a_ready;
                b_acc   = b_valid & b_ready;
                if (a_acc) begin
                    wa_nxt = a_addr;
                    wd_nxt = a_data;
                    we_nxt = |a_addr;
                end else if (b_acc) begin
                    wa_nxt = b_addr;
                    wd_nxt = b_data;
                    we_nxt = |b_addr;
                end
                if (a_valid & b_valid)
                    rr_nxt = a_acc;
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_STATE;
            rr    <= 1'b0;
            rf_we <= 1'b0;
            rf_wa <= 5'd0;
            rf_wd <= 32'd0;
`ifdef RF_CLEAR_EN
            idx   <= 5'd1;
`endif
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            rf_we <= we_nxt;
            rf_wa <= wa_nxt;
            rf_wd <= wd_nxt;
`ifdef RF_CLEAR_EN
            idx   <= idx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed cases plus random traffic, checked by a write scoreboard.
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_we, busy;

    rf_wb_sched dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en = 1'b0;

    // reference requester state
    bit          a_pend = 0, b_pend = 0;
    logic [4:0]  a_pa, b_pa;
    logic [31:0] a_pd, b_pd;
    bit          b_has_priority = 0;   // whoever lost the last contest is served next

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one request cycle: present pending requests, check readies, predict the grant
    task automatic drive(output int grant);
        bit exp_ar, exp_br;
        @(negedge clk);
        a_valid = a_pend; a_addr = a_pa; a_data = a_pd;
        b_valid = b_pend; b_addr = b_pa; b_data = b_pd;
        #1;
        exp_ar = !b_pend || !b_has_priority;
        exp_br = !a_pend || b_has_priority;
        chk("a_ready", a_ready, exp_ar);
        chk("b_ready", b_ready, exp_br);
        grant = 0;
        if (a_pend && exp_ar) grant = 1;
        else if (b_pend && exp_br) grant = 2;
        if (a_pend && b_pend) b_has_priority = (grant == 1);
        if (grant == 1) begin
            if (a_pa != 0) exp_q.push_back('{a_pa, a_pd});
            a_pend = 0;
        end else if (grant == 2) begin
            if (b_pa != 0) exp_q.push_back('{b_pa, b_pd});
            b_pend = 0;
        end
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) drive(g);
    endtask

    task automatic drain();
        int g;
        for (int i = 0; i < 6 && (a_pend || b_pend); i++) drive(g);
        idle(3);
    endtask

    task automatic release_rst();
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        rst = 1'b1;
        #1;
`ifdef RF_CLEAR_EN
        chk("rel busy", busy, 1);
        chk("rel a_ready", a_ready, 0);
        chk("rel rf_we", rf_we, 0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk("sweep rf_we", rf_we, 1);
            chk("sweep rf_wa", rf_wa, k);
            chk("sweep rf_wd", rf_wd, 0);
            chk("sweep busy", busy, 1);
            chk("sweep a_ready", a_ready, 0);
        end
        @(posedge clk); #1;
        chk("c32 busy", busy, 0);
        chk("c32 a_ready", a_ready, 1);
        chk("c32 rf_we", rf_we, 0);
`else
        chk("rel busy", busy, 0);
        chk("rel a_ready", a_ready, 1);
        chk("rel rf_we", rf_we, 0);
        @(posedge clk); #1;
        chk("idle rf_we", rf_we, 0);
        chk("idle busy", busy, 0);
`endif
        mon_en = 1'b1;
    endtask

    task automatic assert_rst();
        mon_en = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        a_pend = 0; b_pend = 0; b_has_priority = 0;
        #1;
        chk("rst rf_we", rf_we, 0);
        chk("rst rf_wa", rf_wa, 0);
        chk("rst rf_wd", rf_wd, 0);
        chk("rst a_ready", a_ready, 0);
        chk("rst b_ready", b_ready, 0);
    endtask

    // monitor: every visible write must match the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(posedge clk); #2;
            if (mon_en && rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected write: got wa=%0d wd=%0h expected none", rf_wa, rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr addr", rf_wa, e.addr);
                    chk("wr data", rf_wd, e.data);
                end
            end
        end
    end

    initial begin
        int g;
        #1;
        chk("init rf_we", rf_we, 0);
`ifdef RF_CLEAR_EN
        chk("init busy", busy, 1);
`else
        chk("init busy", busy, 0);
`endif
        chk("init a_ready", a_ready, 0);
        #20;
        release_rst();

        // sustained contention: A->x1, B->x2, each re-presented once accepted
        for (int i = 0; i < 4; i++) begin
            if (!a_pend) begin a_pend = 1; a_pa = 5'd1; a_pd = 32'h11; end
            if (!b_pend) begin b_pend = 1; b_pa = 5'd2; b_pd = 32'h22; end
            drive(g);
            chk("contest grant", g, (i % 2 == 0) ? 1 : 2);
        end
        drain();

        // win a contest with A so B has priority, then an uncontested A write must not move it
        a_pend = 1; a_pa = 5'd3; a_pd = 32'h33;
        b_pend = 1; b_pa = 5'd4; b_pd = 32'h44;
        drive(g);
        chk("pre grant", g, 1);
        drain();
        a_pend = 1; a_pa = 5'd5; a_pd = 32'hDEADBEEF;
        drive(g);
        chk("a only grant", g, 1);
        @(posedge clk); #1;
        chk("a only rf_we", rf_we, 1);
        chk("a only rf_wa", rf_wa, 5);
        chk("a only rf_wd", rf_wd, 32'hDEADBEEF);
        a_pend = 1; a_pa = 5'd6; a_pd = 32'h66;
        b_pend = 1; b_pa = 5'd7; b_pd = 32'h77;
        drive(g);
        chk("rr kept grant", g, 2);
        drain();

        // write to x0 is accepted but produces no write
        b_pend = 1; b_pa = 5'd0; b_pd = 32'h1234;
        drive(g);
        chk("x0 grant", g, 2);
        @(posedge clk); #1;
        chk("x0 rf_we", rf_we, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(9) < 6) begin
                a_pend = 1; a_pa = 5'($urandom_range(31)); a_pd = $urandom;
            end
            if (!b_pend && $urandom_range(9) < 6) begin
                b_pend = 1; b_pa = 5'($urandom_range(31)); b_pd = $urandom;
                if ($urandom_range(3) == 0) b_pa = a_pa;
            end
            drive(g);
        end
        drain();
        chk("queue empty", exp_q.size(), 0);

        // reset with a write in flight: the write must vanish immediately
        a_pend = 1; a_pa = 5'd9; a_pd = 32'h99;
        drive(g);
        @(posedge clk); #1;
        assert_rst();
        release_rst();

`ifdef RF_CLEAR_EN
        // reset part-way through the sweep restarts it from x1
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                if (rf_we === 1'b1 && rf_wa == 5'd17) seen = 1;
            end
            chk("reached idx17", seen, 1);
        end
        assert_rst();
        release_rst();
`endif

        a_pend = 1; a_pa = 5'd10; a_pd = 32'hA5A5;
        b_pend = 1; b_pa = 5'd10; b_pd = 32'h5A5A;
        drive(g);
        chk("post rst grant", g, 1);
        drain();
        chk("final queue empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
